udma_ethernet_tx_ctrl: RTL and testbench
========================================

# udma_ethernet_tx_ctrl

TX frame sequencer between the uDMA TX channel and the RGMII MAC's 8-bit AXI-stream transmit input inside the Ethernet uDMA peripheral. It takes a software-programmed frame length and start command, fetches 32-bit words from L2 through the uDMA request/grant and valid/ready handshakes, and serializes them LSB-first into bytes with correct `tlast` framing. It also handles abort on TX disable, reports completion, and keeps a frame counter for the register interface.

## Interface
Parameters:
- `LEN_W`, default 11: width of the frame byte length. Maximum frame is 2^LEN_W-1 bytes.
- `CNT_W`, default 16: width of the sent-frame counter.

Ports:
- `sys_clk_i` in 1: the single clock.
- `rstn_i` in 1: reset, synchronous and active-low.
- `en_tx_i` in 1: TX enable from the register interface. Low while busy aborts the frame.
- `start_i` in 1: single-cycle start pulse.
- `frame_len_i` in LEN_W: frame length in bytes, sampled on an accepted start.
- `busy_o` out 1: high from an accepted start until the cycle after the last beat or abort beat.
- `done_o` out 1: one-cycle pulse on normal completion.
- `abort_o` out 1: one-cycle pulse on abort completion.
- `frames_sent_o` out CNT_W: count of normally completed frames. Wraps.
- `data_tx_req_o` out 1: uDMA word request.
- `data_tx_gnt_i` in 1: uDMA request grant.
- `data_tx_i` in 32: uDMA data word.
- `data_tx_valid_i` in 1: uDMA data valid.
- `data_tx_ready_o` out 1: ready to accept a uDMA data word.
- `tx_axis_tdata_o` out 8: byte to the MAC.
- `tx_axis_tvalid_o` out 1: AXI-stream valid.
- `tx_axis_tready_i` in 1: AXI-stream ready.
- `tx_axis_tlast_o` out 1: last byte of the frame.
- `tx_axis_tuser_o` out 1: bad-frame marker, asserted only on the abort beat.

## Operation
The controller is a state machine with states IDLE, REQ, WAIT, SHIFT, ABORT and FIN.

- **IDLE**
  - A start is accepted when `start_i`=1, `en_tx_i`=1 and `frame_len_i`≠0.
  - On acceptance, latch `rem`=`frame_len_i` and go to REQ.
  - A start with `frame_len_i`=0 or `en_tx_i`=0 is ignored and produces no pulse.
  - `start_i` is ignored in every other state.
- **REQ**
  - `data_tx_req_o`=1.
  - When `data_tx_gnt_i`=1, go to WAIT.
  - If `en_tx_i`=0 is seen before the grant, go to ABORT and issue no request.
- **WAIT**
  - `data_tx_ready_o`=1.
  - When `data_tx_valid_i`=1, load `sreg`=`data_tx_i`, set `bidx`=0 and go to SHIFT.
  - `en_tx_i` is not sampled here. The granted word is always consumed so the uDMA stays in sync.
- **SHIFT**
  - Outputs: `tvalid`=1, `tdata`=`sreg[7:0]`, `tlast`=(`rem`==1), `tuser`=0.
  - On handshake: `sreg`>>=8, `rem`--, `bidx`++.
  - Next state after the handshake:
    - `rem` was 1: go to FIN.
    - Otherwise, if `en_tx_i`=0: go to ABORT.
    - Otherwise, if `bidx` was 3: go to REQ.
    - Otherwise: stay in SHIFT.
  - Unused bytes of the final word (for `rem`<4) are discarded.
- **ABORT**
  - Outputs: `tvalid`=1, `tdata`=0x00, `tlast`=1, `tuser`=1.
  - On handshake: pulse `abort_o` and go to IDLE.
- **FIN**
  - One cycle: pulse `done_o`, `frames_sent_o`++, go to IDLE.

Rules and boundary conditions:
- Words fetched per frame = ceil(`frame_len_i`/4), exactly.
- AXI-stream rule: once `tvalid` is high, `tdata`, `tlast` and `tuser` are held until `tready`. An abort is only taken at a beat boundary, never mid-beat.
- `frames_sent_o` wraps from 2^CNT_W-1 to 0.
- Abort does not increment `frames_sent_o`.
- `busy_o` = state≠IDLE.

## Timing
- Reset values (`rstn_i`=0 sampled on an edge):
  - State IDLE; `sreg`, `rem` and `bidx` cleared.
  - All outputs 0, including `frames_sent_o`.
  - Reset mid-frame drops everything immediately with no abort beat.
- All outputs are decoded from registered state and registers, so there are no combinational paths from inputs to outputs.
- Latency:
  - Start accepted at edge N: `data_tx_req_o` high in cycle N+1.
  - Grant in cycle G: `data_tx_ready_o` high in G+1.
  - Valid in cycle V: first byte valid in V+1.
- Peak throughput is 4 bytes per 6 cycles (1 REQ + 1 WAIT + 4 SHIFT), with no prefetch.
- `done_o` pulses in the cycle after the `tlast` handshake; the next start is accepted the cycle after that.

## Test plan
- **Basic 8-byte frame:** len=8, words 0x44332211 and 0x88776655, `tready` always high → 2 requests; bytes 11..88 in order; `tlast` on 0x88 only; `done_o` one cycle later; `frames_sent_o`=1.
- **Partial last word:** len=5, words 0xDDCCBBAA and 0x000000EE → bytes AA BB CC DD EE; `tlast` on EE; exactly 2 requests.
- **Backpressure:** len=4, random `tready` gaps → `tdata` and `tlast` stable during stalls; no byte lost or duplicated.
- **Abort mid-frame:** len=12, drop `en_tx_i` after the 3rd handshake → 3 data bytes, then 0x00 beat with `tlast`=1 and `tuser`=1; `abort_o` pulse; counter unchanged; second word never requested.
- **Start filtering:** start with len=0, start with `en_tx_i`=0, and start while busy → ignored; no requests, no pulses.
- **Counter wrap and reset:** CNT_W=2, 5 frames → `frames_sent_o`=1; reset asserted mid-SHIFT → all outputs 0 on the next cycle.

Source files
------------

// File: rtl/udma_ethernet_tx_ctrl.sv
// udma_ethernet_tx_ctrl: uDMA-to-AXI-stream TX frame sequencer for the Ethernet MAC.
// Ports:
//   sys_clk_i, rstn_i            clock, synchronous active-low reset
//   en_tx_i, start_i, frame_len_i  register-interface control (length sampled on accepted start)
//   busy_o, done_o, abort_o      status: busy, normal-completion pulse, abort-completion pulse
//   frames_sent_o                wrapping count of normally completed frames
//   data_tx_req_o/gnt_i          uDMA word request/grant
//   data_tx_i/valid_i/ready_o    uDMA data word handshake
//   tx_axis_*                    8-bit AXI-stream to the MAC (tuser marks the abort beat)
module udma_ethernet_tx_ctrl #(
    parameter int LEN_W = 11,
    parameter int CNT_W = 16
) (
    input  logic             sys_clk_i,
    input  logic             rstn_i,
    input  logic             en_tx_i,
    input  logic             start_i,
    input  logic [LEN_W-1:0] frame_len_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             abort_o,
    output logic [CNT_W-1:0] frames_sent_o,
    output logic             data_tx_req_o,
    input  logic             data_tx_gnt_i,
    input  logic [31:0]      data_tx_i,
    input  logic             data_tx_valid_i,
    output logic             data_tx_ready_o,
    output logic [7:0]       tx_axis_tdata_o,
    output logic             tx_axis_tvalid_o,
    input  logic             tx_axis_tready_i,
    output logic             tx_axis_tlast_o,
    output logic             tx_axis_tuser_o
);
    typedef enum logic [2:0] {IDLE, REQ, WAIT, SHIFT, ABORT, FIN} state_t;

    state_t           state, state_nx;
    logic [31:0]      sreg;
    logic [LEN_W-1:0] rem;
    logic [1:0]       bidx;
    logic [CNT_W-1:0] frames;
    logic             abort_q;
    logic             accept;

    assign accept = (state == IDLE) && start_i && en_tx_i && (frame_len_i != '0);

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = accept ? REQ : IDLE;
            // Abort is only honoured before the grant; once granted the word must be drained.
            REQ:     state_nx = !en_tx_i ? ABORT : data_tx_gnt_i ? WAIT : REQ;
            WAIT:    state_nx = data_tx_valid_i ? SHIFT : WAIT;
            SHIFT:   state_nx = !tx_axis_tready_i ? SHIFT :
                                (rem == LEN_W'(1)) ? FIN :
                                !en_tx_i ? ABORT :
                                (bidx == 2'd3) ? REQ : SHIFT;
            ABORT:   state_nx = tx_axis_tready_i ? IDLE : ABORT;
            FIN:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk_i) begin
        if (!rstn_i) begin
            state   <= IDLE;
            sreg    <= '0;
            rem     <= '0;
            bidx    <= '0;
            frames  <= '0;
            abort_q <= 1'b0;
        end else begin
            state   <= state_nx;
            // Registered so abort_o has no combinational path from tready.
            abort_q <= (state == ABORT) && tx_axis_tready_i;
            if (accept)
                rem <= frame_len_i;
            if (state == WAIT && data_tx_valid_i) begin
                sreg <= data_tx_i;
                bidx <= '0;
            end
            if (state == SHIFT && tx_axis_tready_i) begin
                sreg <= {8'h00, sreg[31:8]};
                rem  <= rem - LEN_W'(1);
                bidx <= bidx + 2'd1;
            end
            if (state == FIN)
                frames <= frames + CNT_W'(1);
        end
    end

    assign busy_o           = (state != IDLE);
    assign done_o           = (state == FIN);
    assign abort_o          = abort_q;
    assign frames_sent_o    = frames;
    assign data_tx_req_o    = (state == REQ);
    assign data_tx_ready_o  = (state == WAIT);
    assign tx_axis_tvalid_o = (state == SHIFT) || (state == ABORT);
    assign tx_axis_tdata_o  = (state == SHIFT) ? sreg[7:0] : 8'h00;
    assign tx_axis_tlast_o  = (state == SHIFT) ? (rem == LEN_W'(1)) : (state == ABORT);
    assign tx_axis_tuser_o  = (state == ABORT);
endmodule

// File: tb/tb_udma_ethernet_tx_ctrl.sv
// tb_udma_ethernet_tx_ctrl: directed self-checking bench for udma_ethernet_tx_ctrl (CNT_W=2 to exercise wrap).
module tb_udma_ethernet_tx_ctrl;
    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        en = 1'b1;
    logic        start = 1'b0;
    logic [10:0] flen = '0;
    logic        busy, done, abrt;
    logic [1:0]  frames;
    logic        req, gnt = 1'b0;
    logic [31:0] wdata = '0;
    logic        wvalid = 1'b0;
    logic        wready;
    logic [7:0]  tdata;
    logic        tvalid, tlast, tuser;
    logic        tready = 1'b0;

    int errors = 0;
    int checks = 0;

    logic [31:0] words[0:3];
    logic [7:0]  got_d[$];
    logic        got_l[$];
    logic        got_u[$];
    int          nreq, ndone, nabort, hs_c, end_c;

    always #5 clk = ~clk;

    udma_ethernet_tx_ctrl #(.LEN_W(11), .CNT_W(2)) dut (
        .sys_clk_i(clk), .rstn_i(rstn), .en_tx_i(en), .start_i(start), .frame_len_i(flen),
        .busy_o(busy), .done_o(done), .abort_o(abrt), .frames_sent_o(frames),
        .data_tx_req_o(req), .data_tx_gnt_i(gnt), .data_tx_i(wdata),
        .data_tx_valid_i(wvalid), .data_tx_ready_o(wready),
        .tx_axis_tdata_o(tdata), .tx_axis_tvalid_o(tvalid), .tx_axis_tready_i(tready),
        .tx_axis_tlast_o(tlast), .tx_axis_tuser_o(tuser)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Runs one frame with an always-granting uDMA model and an AXI sink; records every beat.
    task automatic drive_frame(input int len, input bit rnd_ready, input int abort_after, input bit restart);
        int widx = 0;
        bit stalled = 0, prev_gnt = 0, prev_valid = 0;
        logic [7:0] pd = '0;
        logic pl = 0, pu = 0;
        got_d.delete(); got_l.delete(); got_u.delete();
        nreq = 0; ndone = 0; nabort = 0; hs_c = -1; end_c = -1;
        en = 1; start = 1; flen = 11'(len);
        step();
        start = 0;
        for (int c = 0; c < 300; c++) begin
            if (c == 0) begin
                checks++;
                if (req !== 1'b1) $display("FAIL start_latency: req=%b expected 1", req);
                if (req !== 1'b1) errors++;
            end
            if (prev_gnt) begin
                checks++;
                if (wready !== 1'b1) begin errors++; $display("FAIL grant_latency: ready=%b expected 1", wready); end
            end
            if (prev_valid) begin
                checks++;
                if (tvalid !== 1'b1) begin errors++; $display("FAIL valid_latency: tvalid=%b expected 1", tvalid); end
            end
            if (stalled) begin
                checks++;
                if (tvalid !== 1'b1 || tdata !== pd || tlast !== pl || tuser !== pu) begin
                    errors++;
                    $display("FAIL stall_hold: v=%b d=%h l=%b u=%b expected v=1 d=%h l=%b u=%b", tvalid, tdata, tlast, tuser, pd, pl, pu);
                end
            end
            if (done || abrt) begin
                ndone += int'(done); nabort += int'(abrt); end_c = c;
                break;
            end
            start = restart && (c == 2);
            if (start) flen = 11'd8;
            gnt = req;
            nreq += int'(req);
            prev_gnt = req;
            wvalid = wready;
            wdata = (wready && widx < 4) ? words[widx] : 32'h0;
            if (wready) widx++;
            prev_valid = wready;
            tready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (tvalid && tready) begin
                got_d.push_back(tdata); got_l.push_back(tlast); got_u.push_back(tuser);
                hs_c = c;
                if (got_d.size() == abort_after) en = 0;
            end
            stalled = tvalid && !tready;
            pd = tdata; pl = tlast; pu = tuser;
            step();
        end
        gnt = 0; wvalid = 0; tready = 0; start = 0;
        checks++;
        if (end_c < 0) begin errors++; $display("FAIL frame_timeout: no done/abort within budget"); end
        checks++;
        if (end_c != hs_c + 1) begin errors++; $display("FAIL end_latency: end cycle %0d expected %0d", end_c, hs_c + 1); end
        step();
        en = 1;
        checks++;
        if (done !== 1'b0 || abrt !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL pulse_width: done=%b abort=%b busy=%b expected 0 0 0", done, abrt, busy);
        end
    endtask

    task automatic check_bytes(input string name, input logic [7:0] exp_d[$], input int exp_req,
                               input int exp_done, input int exp_abort, input logic [1:0] exp_frames);
        checks++;
        if (got_d.size() != exp_d.size()) begin
            errors++; $display("FAIL %s_count: bytes=%0d expected %0d", name, got_d.size(), exp_d.size());
        end else begin
            for (int i = 0; i < exp_d.size(); i++) begin
                logic el, eu;
                el = (i == exp_d.size() - 1);
                eu = el && (exp_abort != 0);
                checks++;
                if (got_d[i] !== exp_d[i] || got_l[i] !== el || got_u[i] !== eu) begin
                    errors++;
                    $display("FAIL %s_beat%0d: d=%h l=%b u=%b expected d=%h l=%b u=%b", name, i, got_d[i], got_l[i], got_u[i], exp_d[i], el, eu);
                end
            end
        end
        checks++;
        if (nreq != exp_req) begin errors++; $display("FAIL %s_requests: %0d expected %0d", name, nreq, exp_req); end
        checks++;
        if (ndone != exp_done || nabort != exp_abort) begin
            errors++; $display("FAIL %s_pulses: done=%0d abort=%0d expected %0d %0d", name, ndone, nabort, exp_done, exp_abort);
        end
        checks++;
        if (frames !== exp_frames) begin errors++; $display("FAIL %s_frames: %0d expected %0d", name, frames, exp_frames); end
    endtask

    task automatic test_reset();
        rstn = 0;
        step(); step();
        checks++;
        if ({busy, done, abrt, frames, req, wready, tdata, tvalid, tlast, tuser} !== 16'h0) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected 0", {busy, done, abrt, frames, req, wready, tdata, tvalid, tlast, tuser});
        end
        rstn = 1;
        step();
    endtask

    task automatic test_basic();
        words[0] = 32'h44332211; words[1] = 32'h88776655;
        drive_frame(8, 0, -1, 0);
        check_bytes("basic", '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88}, 2, 1, 0, 2'd1);
    endtask

    task automatic test_partial();
        words[0] = 32'hDDCCBBAA; words[1] = 32'h000000EE;
        drive_frame(5, 0, -1, 0);
        check_bytes("partial", '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE}, 2, 1, 0, 2'd2);
    endtask

    task automatic test_backpressure();
        words[0] = 32'hA1B2C3D4;
        drive_frame(4, 1, -1, 0);
        check_bytes("backpressure", '{8'hD4, 8'hC3, 8'hB2, 8'hA1}, 1, 1, 0, 2'd3);
    endtask

    task automatic test_abort();
        words[0] = 32'h04030201; words[1] = 32'h08070605; words[2] = 32'h0C0B0A09;
        drive_frame(12, 0, 3, 0);
        check_bytes("abort", '{8'h01, 8'h02, 8'h03, 8'h00}, 1, 0, 1, 2'd3);
    endtask

    task automatic test_start_filter();
        int activity = 0;
        for (int k = 0; k < 2; k++) begin
            start = 1; flen = (k == 0) ? 11'd0 : 11'd8; en = (k == 0);
            step();
            start = 0; en = 1;
            for (int c = 0; c < 6; c++) begin
                activity += int'(req | busy | done | abrt | tvalid);
                step();
            end
            checks++;
            if (activity != 0) begin errors++; $display("FAIL filter_case%0d: activity=%0d expected 0", k, activity); end
        end
        words[0] = 32'h5A6B7C8D;
        drive_frame(4, 0, -1, 1);
        check_bytes("start_busy", '{8'h8D, 8'h7C, 8'h6B, 8'h5A}, 1, 1, 0, 2'd0);
        activity = 0;
        for (int c = 0; c < 6; c++) begin
            activity += int'(req | busy);
            step();
        end
        checks++;
        if (activity != 0) begin errors++; $display("FAIL start_busy_idle: activity=%0d expected 0", activity); end
    endtask

    task automatic test_wrap();
        words[0] = 32'hCAFEF00D;
        drive_frame(3, 0, -1, 0);
        check_bytes("wrap", '{8'h0D, 8'hF0, 8'hFE}, 1, 1, 0, 2'd1);
    endtask

    task automatic test_reset_mid();
        int c = 0;
        words[0] = 32'h11223344;
        en = 1; start = 1; flen = 11'd8;
        step();
        start = 0;
        while (!tvalid && c < 20) begin
            gnt = req; wvalid = wready; wdata = words[0];
            step();
            c++;
        end
        gnt = 0; wvalid = 0;
        checks++;
        if (tvalid !== 1'b1) begin errors++; $display("FAIL reset_mid_reach: tvalid=%b expected 1", tvalid); end
        rstn = 0;
        step();
        checks++;
        if ({busy, done, abrt, frames, req, wready, tdata, tvalid, tlast, tuser} !== 16'h0) begin
            errors++;
            $display("FAIL reset_mid_outputs: got %h expected 0", {busy, done, abrt, frames, req, wready, tdata, tvalid, tlast, tuser});
        end
        rstn = 1;
        step();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_partial();
        test_backpressure();
        test_abort();
        test_start_filter();
        test_wrap();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
